// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: drain FSM encoding and the
// default word width shared with the transmitter.
package uart_pkg;

    localparam int PAYLOAD_BITS_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } drain_state_t;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered count, full/empty flags and a sticky
// overflow flag. Pushes while full are dropped; pops come only from the
// drain controller through the pop strobe.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // Flags come from the registered count, so a pop never frees a slot for a
    // push in the same cycle.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = wr_en && !w_full;
    assign w_pop   = pop && !w_empty;

    // Storage write; no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign rd_data  = r_mem[r_rd_ptr];
    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers producer words and issues them one at a time to the UART
// transmitter using its enable/busy handshake.
// Handshake: tx_en is a one-cycle request carrying tx_data; it is raised only
// from IDLE with tx_busy low, and the next word waits until busy has been seen
// high and then low again, so at most one word is outstanding.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEFAULT,
    parameter int DEPTH        = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [PAYLOAD_BITS-1:0]   wr_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      tx_en,
    output logic [PAYLOAD_BITS-1:0]   tx_data,
    input  logic                      tx_busy,
    output logic [1:0]                dbg_state
);

    drain_state_t              r_state;
    drain_state_t              w_next_state;
    logic                      w_issue;
    logic [PAYLOAD_BITS-1:0]   w_rd_data;
    logic                      w_empty;
    logic                      r_tx_en;
    logic [PAYLOAD_BITS-1:0]   r_tx_data;

    fifo_sync #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .pop      (w_issue),
        .rd_data  (w_rd_data),
        .full     (full),
        .empty    (w_empty),
        .count    (count),
        .overflow (overflow)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: issue, then wait for busy to rise and fall.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      if (!w_empty && !tx_busy) w_next_state = ISSUE;
            ISSUE:     w_next_state = WAIT_BUSY;
            WAIT_BUSY: if (tx_busy)  w_next_state = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    // Output decode: the issue strobe pops the FIFO and loads the tx registers.
    always_comb begin
        w_issue = 1'b0;
        if (r_state == IDLE && !w_empty && !tx_busy) begin
            w_issue = 1'b1;
        end
    end

    // Transmitter request registers; tx_data holds until the next issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_en   <= 1'b0;
            r_tx_data <= '0;
        end else begin
            r_tx_en <= w_issue;
            if (w_issue) begin
                r_tx_data <= w_rd_data;
            end
        end
    end

    assign empty     = w_empty;
    assign tx_en     = r_tx_en;
    assign tx_data   = r_tx_data;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple transmitter model that raises
// busy the edge after tx_en and holds it for 10 cycles.
module tb_uart_tx_fifo;

    localparam int W     = 8;
    localparam int DEPTH = 16;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     wr_en;
    logic [W-1:0]             wr_data;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     tx_en;
    logic [W-1:0]             tx_data;
    logic                     tx_busy;
    logic [1:0]               dbg_state;

    int errors = 0;
    int checks = 0;

    // transmitter model state
    logic                     hold_busy = 1'b0;
    int                       busy_cnt  = 0;
    int                       pulses    = 0;
    int                       viol      = 0;
    logic [W-1:0]             rx_q[$];
    logic [W-1:0]             exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    uart_tx_fifo #(.PAYLOAD_BITS(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .dbg_state (dbg_state)
    );

    assign tx_busy = hold_busy || (busy_cnt != 0);

    // transmitter model: captures each request, busy for 10 cycles after it
    always @(posedge clk) begin
        if (tx_en === 1'b1) begin
            rx_q.push_back(tx_data);
            pulses = pulses + 1;
            if (tx_busy) viol = viol + 1;
            busy_cnt <= 10;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, input string tag);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < max_cycles; n++) begin
            if (dbg_state == 2'd0 && empty && !tx_busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    // scoreboard: compare received words against the expected queue, then clear
    task automatic check_rx(input string tag);
        chk({tag, "_len"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            chk($sformatf("%s_w%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;

        // reset state
        tick();
        tick();
        chk("rst_empty",    {31'd0, empty},    32'd1);
        chk("rst_full",     {31'd0, full},     32'd0);
        chk("rst_count",    {27'd0, count},    32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_tx_en",    {31'd0, tx_en},    32'd0);
        chk("rst_tx_data",  {24'd0, tx_data},  32'd0);
        chk("rst_state",    {30'd0, dbg_state}, 32'd0);
        reset = 1'b0;
        tick();

        // single word
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        chk("single_count1", {27'd0, count}, 32'd1);
        chk("single_empty0", {31'd0, empty}, 32'd0);
        chk("single_no_en",  {31'd0, tx_en}, 32'd0);
        tick();
        chk("single_tx_en",   {31'd0, tx_en},   32'd1);
        chk("single_tx_data", {24'd0, tx_data}, 32'h0000_00A5);
        chk("single_count0",  {27'd0, count},   32'd0);
        chk("single_issue",   {30'd0, dbg_state}, 32'd1);
        tick();
        chk("single_en_drop", {31'd0, tx_en},   32'd0);
        chk("single_wbusy",   {30'd0, dbg_state}, 32'd2);
        chk("single_busy",    {31'd0, tx_busy}, 32'd1);
        tick();
        chk("single_wdone",   {30'd0, dbg_state}, 32'd3);
        wait_idle(40, "single_idle");
        chk("single_pulses", pulses, 32'd1);
        exp_q.push_back(8'hA5);
        check_rx("single_rx");

        // burst of 16 with transmitter held busy
        hold_busy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            push(W'(i));
            if (i == 15) chk("burst_full_at15", {31'd0, full}, 32'd0);
            exp_q.push_back(W'(i));
        end
        chk("burst_full",     {31'd0, full},     32'd1);
        chk("burst_count",    {27'd0, count},    32'd16);
        chk("burst_overflow", {31'd0, overflow}, 32'd0);
        chk("burst_no_en",    {31'd0, tx_en},    32'd0);
        hold_busy = 1'b0;
        wait_idle(600, "burst_idle");
        chk("burst_count0", {27'd0, count}, 32'd0);
        check_rx("burst_rx");

        // overflow: 17 pushes while busy, last dropped
        hold_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            push(8'h20 + W'(i));
            if (i < 16) exp_q.push_back(8'h20 + W'(i));
        end
        chk("ovf_flag",  {31'd0, overflow}, 32'd1);
        chk("ovf_count", {27'd0, count},    32'd16);
        chk("ovf_full",  {31'd0, full},     32'd1);
        tick();
        tick();
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        hold_busy = 1'b0;
        wait_idle(600, "ovf_idle");
        chk("ovf_sticky_after", {31'd0, overflow}, 32'd1);
        check_rx("ovf_rx");

        // reset clears overflow
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_overflow", {31'd0, overflow}, 32'd0);
        tick();

        // simultaneous push and pop at count 3
        hold_busy = 1'b1;
        push(8'h41);
        push(8'h42);
        push(8'h43);
        chk("sim_count3", {27'd0, count}, 32'd3);
        hold_busy = 1'b0;
        wr_en = 1'b1; wr_data = 8'h44;
        tick();
        wr_en = 1'b0;
        chk("sim_count_hold", {27'd0, count},   32'd3);
        chk("sim_tx_en",      {31'd0, tx_en},   32'd1);
        chk("sim_tx_data",    {24'd0, tx_data}, 32'h0000_0041);
        wait_idle(200, "sim_idle");
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h43);
        exp_q.push_back(8'h44);
        check_rx("sim_rx");

        // reset while in WAIT_DONE with 5 words left
        hold_busy = 1'b1;
        for (int i = 1; i <= 6; i++) push(8'h50 + W'(i));
        hold_busy = 1'b0;
        tick();
        chk("mid_tx_en",  {31'd0, tx_en},   32'd1);
        chk("mid_count5", {27'd0, count},   32'd5);
        tick();
        tick();
        chk("mid_wdone",  {30'd0, dbg_state}, 32'd3);
        chk("mid_count_wd", {27'd0, count}, 32'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_state", {30'd0, dbg_state}, 32'd0);
        chk("mid_count", {27'd0, count},     32'd0);
        chk("mid_empty", {31'd0, empty},     32'd1);
        chk("mid_tx_en_rst", {31'd0, tx_en}, 32'd0);
        begin
            int p0;
            p0 = pulses;
            repeat (20) tick();
            chk("mid_no_issue", pulses, p0);
        end
        push(8'h66);
        wait_idle(100, "mid_idle");
        exp_q.push_back(8'h51);
        exp_q.push_back(8'h66);
        check_rx("mid_rx");

        chk("no_en_while_busy", viol, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // global time bound
    initial begin
        #500000;
        $display("FAIL timeout simulation did not complete observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
